// File: rtl/regfile_pkg.sv
// Shared constants and the write-request type for the register-bank writeback path.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] adr;
    logic [REG_DATA_W-1:0] value;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result queue: synchronous FIFO of write requests that also exposes every
// slot's valid bit and address so the top can build the busy mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                   clock,
  input  logic                                   resetn,
  input  logic                                   push_i,
  input  wb_req_t                                push_data_i,
  input  logic                                   pop_i,
  output wb_req_t                                head_o,
  output logic                                   full_o,
  output logic                                   empty_o,
  output logic [DEPTH-1:0]                       entry_valid_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]       entry_adr_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] count;
  logic        do_push, do_pop;
  wb_req_t     mem_q [DEPTH];

  // The extra pointer bit tells full (MSBs differ) from empty (pointers equal).
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count   = wptr_q - rptr_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    entry_valid_o = '0;
    entry_adr_o   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] off;
      off              = AW'(i) - rptr_q[AW-1:0];
      entry_valid_o[i] = ({1'b0, off} < count);
      entry_adr_o[i]   = mem_q[i].adr;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and queued load results onto the register bank's single write port,
// with ALU priority, bounded load starvation and a per-register busy mask.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter bit DROP_R0      = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [0:4]  alu_adr,
  input  logic [0:31] alu_value,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [0:4]  load_adr,
  input  logic [0:31] load_value,
  output logic [0:4]  wadr,
  output logic [0:31] wvalue,
  output logic        wenable,
  output logic [0:31] busy
);

  logic                             fifo_full, fifo_empty, fifo_pop, fifo_push;
  wb_req_t                          fifo_head, load_req, sel_req;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_adr;

  logic [7:0]            starve_q, starve_d;
  logic [REG_ADDR_W-1:0] wadr_q, wadr_d;
  logic [REG_DATA_W-1:0] wvalue_q, wvalue_d;
  logic                  wen_q, wen_d;
  logic                  alu_acc, write_sel;
  logic [0:REG_COUNT-1]  busy_d;

  assign load_req  = '{adr: load_adr, value: load_value};
  assign fifo_push = load_valid && !fifo_full;
  assign alu_ready = (starve_q != 8'(STARVE_LIMIT));
  assign load_ready = !fifo_full;
  assign alu_acc   = alu_valid && alu_ready;
  assign fifo_pop  = !alu_acc && !fifo_empty;
  assign write_sel = alu_acc || fifo_pop;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock         (clock),
    .resetn        (resetn),
    .push_i        (fifo_push),
    .push_data_i   (load_req),
    .pop_i         (fifo_pop),
    .head_o        (fifo_head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_adr_o   (entry_adr)
  );

  // The counter only grows while a queued load keeps losing; any pop or an empty queue clears it.
  always_comb begin
    sel_req  = alu_acc ? '{adr: alu_adr, value: alu_value} : fifo_head;
    starve_d = (!fifo_empty && alu_acc) ? starve_q + 8'd1 : 8'd0;
    wadr_d   = write_sel ? sel_req.adr   : wadr_q;
    wvalue_d = write_sel ? sel_req.value : wvalue_q;
    wen_d    = write_sel && !(DROP_R0 && (sel_req.adr == '0));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
      wadr_q   <= '0;
      wvalue_q <= '0;
      wen_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      wadr_q   <= wadr_d;
      wvalue_q <= wvalue_d;
      wen_q    <= wen_d;
    end
  end

  always_comb begin
    busy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) busy_d[entry_adr[i]] = 1'b1;
    end
  end

  assign wadr    = wadr_q;
  assign wvalue  = wvalue_q;
  assign wenable = wen_q;
  assign busy    = busy_d;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-based
// behavioural model of the writeback merge and a model of the register bank.
module tb_regfile_writeback;
  import regfile_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam bit DROP_R0      = 1'b1;

  logic        clock = 1'b0;
  logic        resetn;
  logic        alu_valid, alu_ready;
  logic [0:4]  alu_adr;
  logic [0:31] alu_value;
  logic        load_valid, load_ready;
  logic [0:4]  load_adr;
  logic [0:31] load_value;
  logic [0:4]  wadr;
  logic [0:31] wvalue;
  logic        wenable;
  logic [0:31] busy;

  always #5 clock = ~clock;

  regfile_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DROP_R0(DROP_R0)) dut (
    .clock(clock), .resetn(resetn),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_adr(alu_adr), .alu_value(alu_value),
    .load_valid(load_valid), .load_ready(load_ready), .load_adr(load_adr), .load_value(load_value),
    .wadr(wadr), .wvalue(wvalue), .wenable(wenable), .busy(busy)
  );

  int checkCount = 0;
  int passCount  = 0;

  wb_req_t     mq[$];
  int          starveM;
  logic        expWen;
  int          expAdr;
  logic [31:0] expVal;
  logic [31:0] bankModel [32];
  logic [31:0] bankDut   [32];
  int          wrLog[$];
  bit          lastPush, lastAlu;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  function automatic logic [0:31] modelBusy();
    logic [0:31] b;
    b = '0;
    foreach (mq[i]) b[mq[i].adr] = 1'b1;
    return b;
  endfunction

  task automatic resetModel();
    mq.delete();
    starveM = 0;
    expWen  = 1'b0;
    expAdr  = 0;
    expVal  = '0;
  endtask

  task automatic checkState();
    checkOutput("wenable", wenable, expWen);
    if (expWen) begin
      checkOutput("wadr", wadr, expAdr);
      checkOutput("wvalue", wvalue, expVal);
    end
    checkOutput("busy", busy, modelBusy());
    checkOutput("alu_ready", alu_ready, starveM != STARVE_LIMIT);
    checkOutput("load_ready", load_ready, mq.size() < DEPTH);
  endtask

  // One clock cycle: drive inputs, let the model take the edge, then check mid-cycle
  // and let both banks commit on the falling edge.
  task automatic applyStimulus(input bit av, input int aa, input logic [31:0] avl,
                               input bit lv, input int la, input logic [31:0] lvl);
    bit      aluRdy, ldRdy, had, sel;
    wb_req_t r;
    alu_valid  = av;   alu_adr  = aa[4:0]; alu_value  = avl;
    load_valid = lv;   load_adr = la[4:0]; load_value = lvl;
    @(posedge clock);
    aluRdy   = (starveM != STARVE_LIMIT);
    ldRdy    = (mq.size() < DEPTH);
    had      = (mq.size() > 0);
    lastAlu  = av && aluRdy;
    lastPush = lv && ldRdy;
    sel      = 1'b0;
    r        = '0;
    if (lastAlu) begin
      sel = 1'b1;
      r   = '{adr: aa[4:0], value: avl};
      starveM = had ? starveM + 1 : 0;
    end else if (had) begin
      sel = 1'b1;
      r   = mq.pop_front();
      starveM = 0;
    end else begin
      starveM = 0;
    end
    if (lastPush) mq.push_back('{adr: la[4:0], value: lvl});
    expWen = sel && !(DROP_R0 && r.adr == 0);
    if (sel) begin
      expAdr = int'(r.adr);
      expVal = r.value;
    end
    @(negedge clock);
    checkState();
    if (wenable) begin
      bankDut[wadr] = wvalue;
      wrLog.push_back(int'(wadr));
    end
    if (expWen) begin
      bankModel[expAdr] = expVal;
      checkOutput("bank", bankDut[expAdr], bankModel[expAdr]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    int lowCount;
    logic [0:31] b;
    bit av, lv;
    int aa, la;

    alu_valid = 0; alu_adr = '0; alu_value = '0;
    load_valid = 0; load_adr = '0; load_value = '0;
    for (int i = 0; i < 32; i++) begin bankModel[i] = '0; bankDut[i] = '0; end
    resetModel();
    resetn = 1'b0;
    #12;
    checkOutput("rst_wenable", wenable, 0);
    checkOutput("rst_wadr", wadr, 0);
    checkOutput("rst_wvalue", wvalue, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_alu_ready", alu_ready, 1);
    checkOutput("rst_load_ready", load_ready, 1);
    @(negedge clock);
    resetn = 1'b1;
    idle(10);

    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, '0);
    checkOutput("alu_r5_wadr", wadr, 5);
    idle(1);
    checkOutput("bank_r5", bankDut[5], 32'hDEADBEEF);

    // A single load starved by a continuous ALU stream.
    applyStimulus(1, 3, 32'h33, 1, 7, 32'h1234);
    checkOutput("busy_r7_set", busy[7], 1);
    lowCount = 0;
    for (int i = 0; i < 10; i++) begin
      if (!alu_ready) lowCount++;
      applyStimulus(1, 3, 32'h300 + i, 0, 0, '0);
    end
    checkOutput("starve_low_cycles", lowCount, 1);
    checkOutput("bank_r7", bankDut[7], 32'h1234);
    checkOutput("busy_r7_clear", busy[7], 0);

    // Fill the queue behind the ALU, then drain it in order.
    for (int i = 1; i <= 4; i++) applyStimulus(1, 10, 32'hA0 + i, 1, i, 32'h100 + i);
    checkOutput("full_load_ready", load_ready, 0);
    applyStimulus(1, 10, 32'hA5, 1, 5, 32'h105);
    checkOutput("held_5th", lastPush, 0);
    wrLog.delete();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, '0, 1, 5, 32'h105);
      if (lastPush) break;
    end
    checkOutput("accepted_5th", lastPush, 1);
    idle(6);
    checkOutput("drain_count", wrLog.size(), 5);
    for (int i = 0; i < 5 && i < wrLog.size(); i++) checkOutput("drain_order", wrLog[i], i + 1);

    // Writes to r0 are consumed silently.
    applyStimulus(1, 0, 32'hFFFFFFFF, 1, 0, 32'hABCD);
    checkOutput("busy_r0", busy[0], 1);
    idle(3);
    checkOutput("bank_r0", bankDut[0], 0);

    // Asynchronous reset with queued loads.
    applyStimulus(1, 9, 32'h91, 1, 11, 32'hB1);
    applyStimulus(1, 9, 32'h92, 1, 12, 32'hB2);
    applyStimulus(1, 9, 32'h93, 1, 13, 32'hB3);
    checkOutput("pre_rst_wenable", wenable, 1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("arst_wenable", wenable, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_load_ready", load_ready, 1);
    checkOutput("arst_alu_ready", alu_ready, 1);
    resetModel();
    @(negedge clock);
    resetn = 1'b1;
    wrLog.delete();
    idle(5);
    checkOutput("writes_after_reset", wrLog.size(), 0);

    // Random traffic; ALU never targets a register with a queued load.
    for (int n = 0; n < 500; n++) begin
      av = (n < 250) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) != 0);
      lv = ($urandom_range(0, 1) != 0);
      aa = $urandom_range(0, 31);
      la = $urandom_range(0, 31);
      b  = modelBusy();
      if (b[aa]) av = 1'b0;
      applyStimulus(av, aa, $urandom, lv, la, $urandom);
    end
    idle(8);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
